// File: rtl/fifo_pop_packer.sv
// fifo_pop_packer: drains the fifo pop port and packs PACK beats into one wide word,
// emitting partial words on flush or after an idle timeout.
module fifo_pop_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 16,
    localparam int CW        = $clog2(PACK + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid_i,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    output logic                       in_grant_o,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    output logic [DATA_WIDTH*PACK-1:0] out_data_o,
    output logic [CW-1:0]              out_count_o,
    input  logic                       out_grant_i
);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [DATA_WIDTH*PACK-1:0] buf_q, buf_d;
    logic [CW-1:0]              count_q, count_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       in_grant_q, in_grant_d;
    logic                       out_valid_q, out_valid_d;
    logic                       xfer, expire;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        count_d  = count_q;
        timer_d  = timer_q;
        xfer     = in_valid_i && in_grant_q;
        expire   = 1'b0;
        if (state_q == FILL) begin
            for (int k = 0; k < PACK; k++)
                if (xfer && count_q == CW'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
            count_d = count_q + CW'(xfer);
            if (xfer) begin
                timer_d = '0;
            end else if (count_q != '0 && TIMEOUT != 0) begin
                timer_d = timer_q + TW'(1);
                expire  = timer_d == TW'(TIMEOUT);
            end
            // a flush together with the PACK-th beat still yields a single full word
            if (count_d == CW'(PACK) || (flush_i && count_d != '0) || expire) state_d = HOLD;
        end else if (out_grant_i) begin
            state_d = FILL;
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
        end
        in_grant_d  = state_d == FILL;
        out_valid_d = state_d == HOLD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            buf_q       <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            in_grant_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            in_grant_q  <= in_grant_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_grant_o  = in_grant_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = buf_q;
    assign out_count_o = count_q;
endmodule

// File: tb/tb_fifo_pop_packer.sv
// tb_fifo_pop_packer: vector table, directed corner sequences and a queue-based random model.
module tb_fifo_pop_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int TO = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_grant = 1'b0;
    logic          g16, v16, g0, v0;
    logic [31:0]   d16, d0;
    logic [2:0]    c16, c0;

    always #5 clk = ~clk;

    fifo_pop_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_grant_o(g16), .flush_i(flush), .out_valid_o(v16), .out_data_o(d16),
        .out_count_o(c16), .out_grant_i(out_grant)
    );

    fifo_pop_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(0)) dut_nt (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_grant_o(g0), .flush_i(flush), .out_valid_o(v0), .out_data_o(d0),
        .out_count_o(c0), .out_grant_i(out_grant)
    );

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic eg,
                             input logic [31:0] ed, input logic [2:0] ec);
        check({tag, " out_valid"}, 32'(v16), 32'(ev));
        check({tag, " in_grant"}, 32'(g16), 32'(eg));
        check({tag, " out_data"}, d16, ed);
        check({tag, " out_count"}, 32'(c16), 32'(ec));
    endtask

    // reference model: the accepted beats of the current word, whether it is being offered,
    // and how many idle cycles have passed since the last beat
    logic [7:0] mq[$];
    int         midle;
    logic       mhold, mgr;

    task automatic m_reset();
        mq.delete();
        midle = 0;
        mhold = 1'b0;
        mgr   = 1'b0;
    endtask

    task automatic m_step();
        if (!mhold) begin
            if (in_valid && mgr) begin
                mq.push_back(in_data);
                midle = 0;
            end else if (mq.size() > 0) begin
                midle++;
            end
            if (mq.size() == PK || (flush && mq.size() > 0) || midle == TO) mhold = 1'b1;
        end else if (out_grant) begin
            mhold = 1'b0;
            mq.delete();
            midle = 0;
        end
        mgr = !mhold;
    endtask

    function automatic logic [31:0] m_data();
        logic [31:0] r = '0;
        for (int i = 0; i < mq.size(); i++) r[8*i +: 8] = mq[i];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_grant = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        og;
        logic        ev;
        logic        eg;
        logic [31:0] ed;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl[20];
    int   pv;

    initial begin
        tbl[0]  = '{H, 8'h11, L, H, L, H, 32'h00000011, 3'd1};
        tbl[1]  = '{H, 8'h22, L, H, L, H, 32'h00002211, 3'd2};
        tbl[2]  = '{H, 8'h33, L, H, L, H, 32'h00332211, 3'd3};
        tbl[3]  = '{H, 8'h44, L, H, H, L, 32'h44332211, 3'd4};
        tbl[4]  = '{H, 8'h55, L, H, L, H, 32'h00000000, 3'd0};
        tbl[5]  = '{H, 8'hAA, L, H, L, H, 32'h000000AA, 3'd1};
        tbl[6]  = '{H, 8'hBB, L, H, L, H, 32'h0000BBAA, 3'd2};
        tbl[7]  = '{L, 8'h00, H, H, H, L, 32'h0000BBAA, 3'd2};
        tbl[8]  = '{L, 8'h00, L, H, L, H, 32'h00000000, 3'd0};
        tbl[9]  = '{L, 8'h00, H, H, L, H, 32'h00000000, 3'd0};
        tbl[10] = '{H, 8'h01, L, H, L, H, 32'h00000001, 3'd1};
        tbl[11] = '{H, 8'h02, L, H, L, H, 32'h00000201, 3'd2};
        tbl[12] = '{H, 8'hCC, H, H, H, L, 32'h00CC0201, 3'd3};
        tbl[13] = '{H, 8'hDD, H, L, H, L, 32'h00CC0201, 3'd3};
        tbl[14] = '{L, 8'h00, L, H, L, H, 32'h00000000, 3'd0};
        tbl[15] = '{H, 8'h01, L, H, L, H, 32'h00000001, 3'd1};
        tbl[16] = '{H, 8'h02, L, H, L, H, 32'h00000201, 3'd2};
        tbl[17] = '{H, 8'h03, L, H, L, H, 32'h00030201, 3'd3};
        tbl[18] = '{H, 8'h04, H, H, H, L, 32'h04030201, 3'd4};
        tbl[19] = '{L, 8'h00, L, H, L, H, 32'h00000000, 3'd0};

        m_reset();
        @(negedge clk);
        check_all("reset", L, L, 32'h0, 3'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("release grant before edge", 32'(g16), 32'(0));
        @(negedge clk);
        cyc();
        check("grant after first edge", 32'(g16), 32'(1));

        for (int i = 0; i < 20; i++) begin
            in_valid = tbl[i].v;
            in_data = tbl[i].d;
            flush = tbl[i].f;
            out_grant = tbl[i].og;
            cyc();
            check_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].eg, tbl[i].ed, tbl[i].ec);
        end

        // output backpressure: word held, nothing taken from upstream
        flush = 1'b0;
        out_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i * 8'h11);
            cyc();
        end
        out_grant = 1'b0;
        in_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_all($sformatf("bp%0d", i), H, L, 32'h44332211, 3'd4);
        end
        out_grant = 1'b1;
        cyc();
        check_all("bp release", L, H, 32'h0, 3'd0);
        cyc();
        check_all("bp next lane0", L, H, 32'h00000099, 3'd1);
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();

        // idle timeout on one instance, disabled timeout on the other
        do_reset();
        cyc();
        in_valid = 1'b1;
        in_data = 8'h5A;
        cyc();
        in_valid = 1'b0;
        out_grant = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            check($sformatf("timeout valid k=%0d", k), 32'(v16), 32'(k >= TO));
            check($sformatf("no-timeout valid k=%0d", k), 32'(v0), 32'(0));
            if (k == TO) begin
                check("timeout data", d16, 32'h0000005A);
                check("timeout count", 32'(c16), 32'(1));
            end
        end

        // asynchronous reset in the middle of a fill
        do_reset();
        cyc();
        in_valid = 1'b1;
        in_data = 8'hE1;
        cyc();
        in_data = 8'hE2;
        cyc();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        m_reset();
        #1 check_all("async reset", L, L, 32'h0, 3'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc();
        out_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            cyc();
        end
        check_all("after reset word", H, L, 32'h04030201, 3'd4);
        in_valid = 1'b0;
        cyc();

        // randomized traffic against the model
        do_reset();
        pv = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) pv = (n / 200 % 3 == 0) ? 90 : (n / 200 % 3 == 1) ? 40 : 5;
            in_valid = $urandom_range(0, 99) < pv;
            in_data = 8'($urandom);
            flush = $urandom_range(0, 49) == 0;
            out_grant = $urandom_range(0, 3) != 0;
            cyc();
            check_all($sformatf("rand%0d", n), mhold, mgr, m_data(), 3'(mq.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
